// File: rtl/lane_sched_pkg.sv
// Shared types, widths and helpers for the lane scheduler.
package lane_sched_pkg;

  localparam int X_W      = 10;
  localparam int LEVEL_W  = 3;
  localparam int PERIOD_W = 8;
  localparam int LANE_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARM    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  // One-pixel move with wrap: dir 0 steps right, dir 1 steps left.
  function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x,
                                            input logic           dir,
                                            input logic [X_W-1:0] last_x);
    if (!dir) step_x = (x == last_x) ? '0 : x + 1'b1;
    else      step_x = (x == '0) ? last_x : x - 1'b1;
  endfunction

  // Period after level speed-up, floored at one base tick.
  function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] period,
                                                    input logic [LEVEL_W-1:0]  level);
    if (period > PERIOD_W'(level)) eff_period = period - PERIOD_W'(level);
    else                           eff_period = PERIOD_W'(1);
  endfunction

endpackage

// File: rtl/lane_sched_tick_prescaler.sv
// Base-tick prescaler: counts 0..c_BASE_TICK-1 while enabled and flags the
// terminal count with a one-cycle o_Tick. i_Clear wins over i_Enable.
module tick_prescaler #(
  parameter int c_BASE_TICK = 25000
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Enable,
  input  logic i_Clear,
  output logic o_Tick
);

  localparam int CNT_W = (c_BASE_TICK > 1) ? $clog2(c_BASE_TICK) : 1;
  localparam logic [CNT_W-1:0] c_TERM = CNT_W'(c_BASE_TICK - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running divider that wraps on the terminal count and holds when disabled.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cnt <= '0;
    end else if (i_Clear) begin
      cnt <= '0;
    end else if (i_Enable) begin
      cnt <= (cnt == c_TERM) ? '0 : cnt + 1'b1;
    end
  end

  assign o_Tick = i_Enable && (cnt == c_TERM);

endmodule

// File: rtl/lane_sched.sv
// Car-lane scheduler: one shared base-tick prescaler, one lane advanced per
// clock in a round-robin sweep after each tick.
// Optional feature macro: LANE_SCHED_LEVEL_EN (level counter + period speed-up).
// i_Cfg_Wr is a plain strobe with no back-pressure: it is taken on any edge
// where the FSM is in IDLE (o_Busy low) and the lane index is in range, and
// silently dropped otherwise.
module lane_sched
  import lane_sched_pkg::*;
#(
  parameter int c_GAME_WIDTH = 640,
  parameter int c_LANES      = 4,
  parameter int c_BASE_TICK  = 25000,
  parameter int c_LEVEL_MAX  = 7
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst_L,
  input  logic                     i_Game_Active,
  input  logic                     i_Level_Up,
  input  logic                     i_Cfg_Wr,
  input  logic [LANE_W-1:0]        i_Cfg_Lane,
  input  logic [PERIOD_W-1:0]      i_Cfg_Period,
  input  logic                     i_Cfg_Dir,
  input  logic [X_W-1:0]           i_Cfg_Start_X,
  output logic [X_W*c_LANES-1:0]   o_Car_X_Flat,
  output logic [LEVEL_W-1:0]       o_Level,
  output logic                     o_Busy,
  output state_t                   o_Dbg_State
);

  localparam logic [X_W-1:0]     c_LAST_X    = X_W'(c_GAME_WIDTH - 1);
  localparam logic [LANE_W-1:0]  c_LAST_LANE = LANE_W'(c_LANES - 1);
  localparam logic [LEVEL_W-1:0] c_LVL_MAX   = LEVEL_W'(c_LEVEL_MAX);

  state_t               state, state_nxt;
  logic [LANE_W-1:0]    ptr;
  logic                 settle;
  logic                 busy_q;
  logic [LEVEL_W-1:0]   level;
  logic                 tick;
  logic                 presc_en, presc_clr;
  logic                 reload;
  logic                 cfg_accept;
  logic [PERIOD_W-1:0]  cfg_period;

  // A written period of 0 would never fire; store it as 1.
  assign cfg_period = (i_Cfg_Period == '0) ? PERIOD_W'(1) : i_Cfg_Period;

  // FSM state register.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state and control strobes; dropping i_Game_Active overrides everything.
  always_comb begin
    state_nxt  = state;
    presc_en   = 1'b0;
    presc_clr  = 1'b0;
    reload     = 1'b0;
    cfg_accept = 1'b0;
    case (state)
      ST_IDLE: begin
        reload     = 1'b1;
        cfg_accept = i_Cfg_Wr && (int'(i_Cfg_Lane) < c_LANES);
        if (i_Game_Active) state_nxt = ST_ARM;
      end
      ST_ARM: begin
        presc_clr = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        presc_en = !settle;
        if (tick) state_nxt = ST_UPDATE;
      end
      ST_UPDATE: begin
        if (ptr == c_LAST_LANE) state_nxt = ST_WAIT;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!i_Game_Active) begin
      state_nxt = ST_IDLE;
      reload    = 1'b1;
    end
  end

  // Lane pointer walks 0..c_LANES-1 during UPDATE and rests at 0 otherwise.
  // settle holds the prescaler for the first WAIT cycle after a sweep, so the
  // tick period is c_BASE_TICK + c_LANES + 1 clocks.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      ptr    <= '0;
      settle <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      if (state != ST_UPDATE || !i_Game_Active) ptr <= '0;
      else if (ptr == c_LAST_LANE)              ptr <= '0;
      else                                      ptr <= ptr + 1'b1;
      settle <= (state == ST_UPDATE) && (ptr == c_LAST_LANE) && i_Game_Active;
      busy_q <= (state_nxt != ST_IDLE);
    end
  end

`ifdef LANE_SCHED_LEVEL_EN
  // Level counter: saturating increment while running, cleared on return to IDLE.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)                            level <= '0;
    else if (reload)                         level <= '0;
    else if (i_Level_Up && level != c_LVL_MAX) level <= level + 1'b1;
  end
`else
  logic [LEVEL_W:0] unused_level_in;
  assign unused_level_in = {i_Level_Up, c_LVL_MAX};
  assign level = '0;
`endif

  tick_prescaler #(
    .c_BASE_TICK (c_BASE_TICK)
  ) u_presc (
    .i_Clk    (i_Clk),
    .i_Rst_L  (i_Rst_L),
    .i_Enable (presc_en),
    .i_Clear  (presc_clr),
    .o_Tick   (tick)
  );

  for (genvar g = 0; g < c_LANES; g++) begin : g_lane
    localparam logic [LANE_W-1:0] c_IDX = LANE_W'(g);

    logic [X_W-1:0]      start_x, x;
    logic [PERIOD_W-1:0] period, div_cnt;
    logic                dir;
    logic                wr_hit;

    assign wr_hit = cfg_accept && (i_Cfg_Lane == c_IDX);

    // Per-lane state: config write, reload to spawn, or divided step when visited.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        start_x <= '0;
        period  <= PERIOD_W'(1);
        dir     <= 1'b0;
        div_cnt <= PERIOD_W'(1);
        x       <= '0;
      end else if (wr_hit) begin
        start_x <= i_Cfg_Start_X;
        period  <= cfg_period;
        dir     <= i_Cfg_Dir;
        div_cnt <= cfg_period;
        x       <= i_Cfg_Start_X;
      end else if (reload) begin
        // Level is (or is about to be) zero here, so the raw period is effective.
        div_cnt <= period;
        x       <= start_x;
      end else if (state == ST_UPDATE && ptr == c_IDX) begin
        if (div_cnt == PERIOD_W'(1)) begin
          div_cnt <= eff_period(period, level);
          x       <= step_x(x, dir, c_LAST_X);
        end else begin
          div_cnt <= div_cnt - 1'b1;
        end
      end
    end

    assign o_Car_X_Flat[X_W*g +: X_W] = x;
  end

  assign o_Level     = level;
  assign o_Busy      = busy_q;
  assign o_Dbg_State = state;

endmodule
